// File: rtl/ps2_frame_tx.sv
// PS/2-style frame transmitter: start, 8 data bits LSB first, odd parity, stop, then a 2-half-period gap.
// Latency: start bit on SDATA one cycle after SEND is accepted; SEND is ignored while BUSY is high.
module ps2_frame_tx #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       send_i,
  input  logic [7:0] code_i,
  output logic       sclk_o,
  output logic       sdata_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int              PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [3:0]      BIT_STOP = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    shift_q, shift_d;   // frame bits 1..10; the start bit is driven directly
  logic [3:0]    bit_q, bit_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          half_q, half_d;     // 0 = SCLK low half, 1 = SCLK high half
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      half_q  <= 1'b0;
      sclk_q  <= 1'b1;
      sdata_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    half_d  = half_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d  = 1'b1;
        sdata_d = 1'b1;
        busy_d  = 1'b0;
        if (send_i) begin
          state_d = S_FRAME;
          shift_d = {1'b1, ~^code_i, code_i};
          bit_d   = '0;
          phase_d = '0;
          half_d  = 1'b0;
          sclk_d  = 1'b0;
          sdata_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_FRAME: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b1;
          end else if (bit_q == BIT_STOP) begin
            // Stop bit finished: both lines high for the inter-frame gap.
            state_d = S_GAP;
            half_d  = 1'b0;
            sclk_d  = 1'b1;
            sdata_d = 1'b1;
          end else begin
            // Next bit goes out together with the falling SCLK edge.
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
            half_d  = 1'b0;
            sclk_d  = 1'b0;
            sdata_d = shift_q[0];
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_GAP: begin
        sclk_d  = 1'b1;
        sdata_d = 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            half_d  = 1'b0;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b1;
        sdata_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: doc/ps2_frame_tx.md
# ps2_frame_tx

PS/2-style serial frame transmitter: takes an 8-bit code and a one-cycle send strobe, and drives an 11-bit frame on SCLK/SDATA from an internal clock divider. The frame is start 0, 8 data bits LSB first, odd parity, stop 1. SDATA changes only while SCLK is low, so a receiver sampling on SCLK rising edges reads the frame correctly. The block sits on the serial side of the design as the counterpart of the keyboard-code receiver.

## Interface
- CLK_DIV, 50: SCLK half-period in CLK cycles; legal range ≥ 2.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- SEND  in  1  request strobe; sampled only when BUSY=0.
- CODE  in  8  code to transmit; captured in the cycle SEND is accepted.
- SCLK  out  1  serial clock; registered; idles high.
- SDATA  out  1  serial data; registered; idles high.
- BUSY  out  1  high from the cycle after acceptance until frame plus gap complete.
- DONE  out  1  one-cycle pulse when the block returns to IDLE after a frame.

## Operation
- Reset values: SCLK=1, SDATA=1, BUSY=0, DONE=0, state IDLE, counters 0.
- States:
  - IDLE: SCLK=1, SDATA=1. If SEND=1, load shift register {1, ~^CODE, CODE, 0} (bit 0 is shifted first) and go to FRAME.
  - FRAME: bit counter 0..10, phase counter 0..CLK_DIV-1, half flag (low/high).
  - GAP: SCLK=1, SDATA=1 for 2*CLK_DIV cycles, then DONE=1 and return to IDLE.
- Per bit:
  - Low phase first: SCLK=0 and SDATA=current bit for CLK_DIV cycles.
  - Then high phase: SCLK=1 and SDATA held for CLK_DIV cycles.
  - At the end of the high phase, shift and advance the bit counter.
  - After the high phase of bit 10 (stop), go to GAP.
- Parity: odd over data plus parity bit, i.e. parity = ~^CODE.
- SEND while BUSY=1 is ignored. It is not queued, and CODE changes are not observed.
- DONE cycle is IDLE (BUSY=0). A SEND in that same cycle is accepted.
- RST mid-frame: the next cycle shows reset values; the frame is truncated with no DONE pulse.
- Bit counter and phase counter never wrap inside a frame. Phase counter width is clog2(CLK_DIV).

## Timing
- Cycle 0 = SEND accepted in IDLE.
- Cycle 1:
  - BUSY=1, SCLK=0, SDATA=0 (start bit).
- Bit k (k=0..10):
  - Falling edge at cycle 1+2k*CLK_DIV, with SDATA updated in the same cycle.
  - Rising edge at cycle 1+(2k+1)*CLK_DIV.
- Frame ends at cycle 1+22*CLK_DIV: SCLK=1, SDATA=1, GAP begins.
- DONE=1 and BUSY=0 at cycle 1+24*CLK_DIV.
- Minimum SEND-to-SEND spacing is 1+24*CLK_DIV cycles.
- No combinational path from inputs to outputs.

## Test plan
- Reset: RST=1 for 3 cycles with SEND=1 -> SCLK=1, SDATA=1, BUSY=0, DONE=0 throughout; no frame starts.
- CLK_DIV=4, CODE=0x1C, SEND pulse at cycle 0:
  - SDATA sampled at SCLK rising edges (cycles 5, 13, …, 85) = 0,0,0,1,1,1,0,0,0,0,1.
  - DONE pulse at cycle 97.
- Parity values:
  - CODE=0x00 -> parity bit 1.
  - CODE=0xFF -> parity bit 1.
  - CODE=0x01 -> parity bit 0.
  - In all three cases the stop bit is 1.
- Busy rejection: SEND with CODE=0xAA, then SEND with CODE=0x55 at cycle 20 -> only 0xAA is transmitted; a single DONE pulse.
- Back-to-back: second SEND (CODE=0x3C) in the DONE cycle -> BUSY drops for exactly that cycle only, and the next frame's start bit appears at the following cycle.
- Mid-frame reset: RST at cycle 40 (CLK_DIV=4) -> SCLK=1, SDATA=1, BUSY=0 at cycle 41; no DONE; a following SEND produces a full, correct frame.
